// File: rtl/game_input_ctrl_if.sv
// Button and game-core signal bundle for game_input_ctrl.
// slave = the controller, master = whatever drives the buttons and reads the outputs.
interface game_input_ctrl_if;
  logic btn_jump_raw;
  logic btn_start_raw;
  logic game_clk;
  logic jump;
  logic start;
  logic jump_db;
  logic start_db;

  modport master (
    output btn_jump_raw, btn_start_raw,
    input  game_clk, jump, start, jump_db, start_db
  );

  modport slave (
    input  btn_jump_raw, btn_start_raw,
    output game_clk, jump, start, jump_db, start_db
  );
endinterface

// File: rtl/game_input_ctrl.sv
// Button synchroniser/debouncer, game_clk divider and one-shot request latches for the game core.
// Optional macro GAME_INPUT_JUMP_HOLD_EN: jump also follows the debounced level (auto-jump while held).
module game_input_chan #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic rise_evt_i,
  input  logic fall_evt_i,
  output logic db_o,
  output logic req_o
);
  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic [1:0]    sync_q;
  logic          stable_q, stable_d, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d, req_q, req_d;
  logic          press_edge;

  assign press_edge = stable_q & ~prev_q;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // seen samples the registered req on the rise, so a req born on that same
  // cycle is carried through one more full game_clk period.
  always_comb begin
    seen_d = seen_q;
    req_d  = req_q;
    if (rise_evt_i) seen_d = req_q;
    if (fall_evt_i && seen_q) begin
      req_d  = 1'b0;
      seen_d = 1'b0;
    end
    if (press_edge) req_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      req_q    <= req_d;
    end
  end

  assign db_o  = stable_q;
  assign req_o = req_q;
endmodule

module game_input_ctrl #(
  parameter int TICK_HALF  = 833334,
  parameter int DEB_CYCLES = 1000000
) (
  input logic              clk,
  input logic              rst,
  game_input_ctrl_if.slave bus
);
  localparam int NUM_BTN = 2;
  localparam int DW      = $clog2(TICK_HALF);

  logic [DW-1:0]      div_q;
  logic               gclk_q;
  logic               tick, rise_evt, fall_evt;
  logic [NUM_BTN-1:0] raw, db, req;

  assign tick     = (div_q == DW'(TICK_HALF - 1));
  assign rise_evt = tick & ~gclk_q;
  assign fall_evt = tick & gclk_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      gclk_q <= 1'b0;
    end else if (tick) begin
      div_q  <= '0;
      gclk_q <= ~gclk_q;
    end else begin
      div_q  <= div_q + DW'(1);
    end
  end

  // lane 0 = jump, lane 1 = start
  assign raw = {bus.btn_start_raw, bus.btn_jump_raw};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    game_input_chan #(.DEB_CYCLES(DEB_CYCLES)) u_chan (
      .clk        (clk),
      .rst        (rst),
      .raw_i      (raw[g]),
      .rise_evt_i (rise_evt),
      .fall_evt_i (fall_evt),
      .db_o       (db[g]),
      .req_o      (req[g])
    );
  end

  assign bus.game_clk = gclk_q;
  assign bus.start    = req[1];
  assign bus.jump_db  = db[0];
  assign bus.start_db = db[1];
`ifdef GAME_INPUT_JUMP_HOLD_EN
  // both terms are flop outputs, so the OR is glitch-free
  assign bus.jump     = req[0] | db[0];
`else
  assign bus.jump     = req[0];
`endif
endmodule

// File: tb/tb_game_input_ctrl.sv
// Directed bench for game_input_ctrl with TICK_HALF=4, DEB_CYCLES=3.
// cyc counts clk edges after reset release; signals are driven and sampled 1 time unit after each edge.
module tb_game_input_ctrl;
  localparam int TH = 4;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst;
  int   cyc, checks, errors;

  game_input_ctrl_if bus_if ();

  game_input_ctrl #(.TICK_HALF(TH), .DEB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all0(input string tag);
    chk({tag, ".game_clk"}, bus_if.game_clk, 1'b0);
    chk({tag, ".jump"},     bus_if.jump,     1'b0);
    chk({tag, ".start"},    bus_if.start,    1'b0);
    chk({tag, ".jump_db"},  bus_if.jump_db,  1'b0);
    chk({tag, ".start_db"}, bus_if.start_db, 1'b0);
  endtask

  initial begin
    logic exp_j;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    bus_if.btn_jump_raw  = 1'b0;
    bus_if.btn_start_raw = 1'b0;

    // reset and free-running divider
    tick();
    tick();
    chk_all0("reset");
    cyc = 0;
    rst = 1'b0;
    tick_to(3);  chk("s1.gclk3", bus_if.game_clk, 1'b0);
    tick_to(4);  chk("s1.gclk4", bus_if.game_clk, 1'b1);
    tick_to(7);  chk("s1.gclk7", bus_if.game_clk, 1'b1);
    tick_to(8);  chk_all0("s1.idle8");

    // 2-cycle glitch is filtered
    bus_if.btn_jump_raw = 1'b1;
    tick_to(10);
    bus_if.btn_jump_raw = 1'b0;
    while (cyc < 18) begin
      tick();
      chk("s2.jump_db", bus_if.jump_db, 1'b0);
      chk("s2.jump",    bus_if.jump,    1'b0);
    end

    // clean press: db after 5 cycles, request one later, cleared on 2nd fall
    bus_if.btn_jump_raw = 1'b1;
    tick_to(22); chk("s3.db22", bus_if.jump_db, 1'b0);
    tick_to(23); chk("s3.db23", bus_if.jump_db, 1'b1);
                 chk("s3.j23",  bus_if.jump,    1'b0);
    tick_to(24); chk("s3.j24",  bus_if.jump,    1'b1);
    tick_to(28); chk("s3.j28",  bus_if.jump,    1'b1);
                 chk("s3.g28",  bus_if.game_clk, 1'b1);
    tick_to(30); bus_if.btn_jump_raw = 1'b0;
    tick_to(31); chk("s3.j31",  bus_if.jump,    1'b1);
    tick_to(32); chk("s3.j32",  bus_if.jump,    1'b0);
                 chk("s3.g32",  bus_if.game_clk, 1'b0);
    tick_to(34); chk("s3.db34", bus_if.jump_db, 1'b1);
    tick_to(35); chk("s3.db35", bus_if.jump_db, 1'b0);
                 chk("s3.start", bus_if.start,  1'b0);

    // two presses before one rise merge into one window (45..55)
    tick_to(39); bus_if.btn_jump_raw = 1'b1;
    tick_to(42); bus_if.btn_jump_raw = 1'b0;
    while (cyc < 60) begin
      tick();
      if (cyc == 45) bus_if.btn_jump_raw = 1'b1;
      if (cyc == 48) bus_if.btn_jump_raw = 1'b0;
      if (cyc >= 44) chk("s4.jump", bus_if.jump, (cyc >= 45 && cyc <= 55));
    end

    // press edge on the rise_evt cycle is held one extra period
    tick_to(62); bus_if.btn_jump_raw = 1'b1;
    tick_to(65); bus_if.btn_jump_raw = 1'b0;
    tick_to(67); chk("s5.j67",  bus_if.jump,     1'b0);
                 chk("s5.db67", bus_if.jump_db,  1'b1);
    tick_to(68); chk("s5.j68",  bus_if.jump,     1'b1);
                 chk("s5.g68",  bus_if.game_clk, 1'b1);
    tick_to(72); chk("s5.j72",  bus_if.jump,     1'b1);
                 chk("s5.g72",  bus_if.game_clk, 1'b0);
    tick_to(76); chk("s5.j76",  bus_if.jump,     1'b1);
    tick_to(79); chk("s5.j79",  bus_if.jump,     1'b1);
    tick_to(80); chk("s5.j80",  bus_if.jump,     1'b0);

    // simultaneous jump+start; a second jump press lands on the clearing fall
    tick_to(82);
    bus_if.btn_jump_raw  = 1'b1;
    bus_if.btn_start_raw = 1'b1;
    tick_to(85);
    bus_if.btn_jump_raw  = 1'b0;
    bus_if.btn_start_raw = 1'b0;
    tick_to(87); chk("sim.jdb87", bus_if.jump_db,  1'b1);
                 chk("sim.sdb87", bus_if.start_db, 1'b1);
                 chk("sim.s87",   bus_if.start,    1'b0);
    tick_to(88); chk("sim.j88",   bus_if.jump,     1'b1);
                 chk("sim.s88",   bus_if.start,    1'b1);
    tick_to(90); bus_if.btn_jump_raw = 1'b1;
    tick_to(93); bus_if.btn_jump_raw = 1'b0;
    tick_to(95); chk("sim.j95",   bus_if.jump,     1'b1);
                 chk("sim.s95",   bus_if.start,    1'b1);
                 chk("sim.jdb95", bus_if.jump_db,  1'b1);
    tick_to(96); chk("sim.s96",   bus_if.start,    1'b0);
                 chk("sim.j96",   bus_if.jump,     1'b1);
    tick_to(100); chk("sim.j100", bus_if.jump,     1'b1);

    // reset mid-operation with jump and game_clk high
    tick_to(102);
    chk("s6.j102", bus_if.jump,     1'b1);
    chk("s6.g102", bus_if.game_clk, 1'b1);
    rst = 1'b1;
    tick();
    chk_all0("s6.rst");
    rst = 1'b0;
    tick_to(106); chk("s6.g106", bus_if.game_clk, 1'b0);
                  chk("s6.j106", bus_if.jump,     1'b0);
    tick_to(107); chk("s6.g107", bus_if.game_clk, 1'b1);
    tick_to(110); chk("s6.j110", bus_if.jump,     1'b0);
                  chk("s6.s110", bus_if.start,    1'b0);

    // long hold: db 120..159; request 121..126 unless hold mode follows db
    tick_to(115); bus_if.btn_jump_raw = 1'b1;
    while (cyc < 165) begin
      tick();
      if (cyc == 155) bus_if.btn_jump_raw = 1'b0;
`ifdef GAME_INPUT_JUMP_HOLD_EN
      exp_j = (cyc >= 120 && cyc <= 159);
`else
      exp_j = (cyc >= 121 && cyc <= 126);
`endif
      chk("hold.jump",    bus_if.jump,    exp_j);
      chk("hold.jump_db", bus_if.jump_db, (cyc >= 120 && cyc <= 159));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
